rv32i_lsu: RTL and testbench

Load/store unit sitting directly downstream of the single-cycle RV32I core's data-memory port. Takes the core's load/store flags, ALU-computed address, store data and funct3, and runs one access per instruction on a word-wide req/ack data bus. Handles byte-lane steering, byte enables and load sign/zero extension. Stalls the core until the access completes.

---
 rtl/rv32i_lsu_pkg.sv | 25 ++
 rtl/rv32i_lsu_lane.sv | 76 +++++++
 rtl/rv32i_lsu.sv | 158 +++++++++++++++
 tb/tb_rv32i_lsu.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM encoding,
// access-size codes and funct3 field positions.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  // Reserved size code, handled as a word access.
  localparam logic [1:0] SZ_X = 2'b11;

  localparam int unsigned F3_SIZE_LSB = 0;
  localparam int unsigned F3_SIZE_MSB = 1;
  localparam int unsigned F3_UNSIGNED = 2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_lsu_lane.sv
// Byte-lane steering for the LSU: store replication, byte enables, load extraction/extension
// and misalignment detection (enabled by RV32I_LSU_MISALIGN_TRAP_EN).
module rv32i_lsu_lane
  import rv32i_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_write,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  size;
  logic        uns;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign size = funct3[F3_SIZE_MSB:F3_SIZE_LSB];
  assign uns  = funct3[F3_UNSIGNED];

  always_comb begin
    sel_byte = rdata_word[7:0];
    unique case (addr_lo)
      2'd0: sel_byte = rdata_word[7:0];
      2'd1: sel_byte = rdata_word[15:8];
      2'd2: sel_byte = rdata_word[23:16];
      2'd3: sel_byte = rdata_word[31:24];
      default: sel_byte = rdata_word[7:0];
    endcase
    sel_half = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
  end

  always_comb begin
    store_data = wdata;
    byte_en    = 4'b1111;
    load_data  = rdata_word;
    unique case (size)
      SZ_B: begin
        store_data = {4{wdata[7:0]}};
        byte_en    = 4'b0001 << addr_lo;
        load_data  = uns ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_H: begin
        // addr_lo[0] deliberately ignored: halfwords are forced onto aligned lanes.
        store_data = {2{wdata[15:0]}};
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        load_data  = uns ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      SZ_W, SZ_X: begin
        store_data = wdata;
        byte_en    = 4'b1111;
        load_data  = rdata_word;
      end
      default: begin
        store_data = wdata;
        byte_en    = 4'b1111;
        load_data  = rdata_word;
      end
    endcase
    if (!is_write) begin
      store_data = '0;
    end
  end

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  assign misaligned = ((size == SZ_H) && addr_lo[0]) ||
                      (((size == SZ_W) || (size == SZ_X)) && (addr_lo != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one req/ack bus access per memory instruction, stalling the core
// until DONE. Misalignment trapping is enabled by defining RV32I_LSU_MISALIGN_TRAP_EN.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_misaligned,
  output logic        cpu_bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW   = (BUS_TIMEOUT == 0) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam int unsigned ToLast = (BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ToLast);
  localparam bit TimeoutEn = (BUS_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        access;
  logic        is_write;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [31:0] lane_rdata;
  logic        lane_mis;

  assign access   = cpu_load | cpu_store;
  // Load wins when both flags are raised.
  assign is_write = cpu_store & ~cpu_load;

  rv32i_lsu_lane u_lane (
    .addr_lo    (cpu_addr[1:0]),
    .funct3     (cpu_funct3),
    .is_write   (is_write),
    .wdata      (cpu_wdata),
    .rdata_word (bus_rdata),
    .store_data (lane_wdata),
    .byte_en    (lane_be),
    .load_data  (lane_rdata),
    .misaligned (lane_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          cnt_d = '0;
          if (lane_mis) begin
            state_d = StDone;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StAccess;
            req_d   = 1'b1;
            we_d    = is_write;
            addr_d  = word_align(cpu_addr);
            wdata_d = lane_wdata;
            be_d    = lane_be;
          end
        end
      end
      StAccess: begin
        if (bus_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          rdata_d = lane_rdata;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          state_d = StDone;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
        mis_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign cpu_stall      = access & (state_q != StDone);
  assign cpu_rdata      = rdata_q;
  assign cpu_misaligned = mis_q;
  assign cpu_bus_error  = err_q;
  assign bus_req        = req_q;
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;
  assign bus_be         = be_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: the driver queues expected bus requests and core responses,
// separate monitors pop and compare them when the DUT presents them.
module tb_rv32i_lsu;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } resp_t;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        cpu_load = 1'b0;
  logic        cpu_store = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [2:0]  cpu_funct3 = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_misaligned;
  logic        cpu_bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_err = 0;
  bus_t  bus_q[$];
  resp_t resp_q[$];

  rv32i_lsu #(.BUS_TIMEOUT(4)) dut (
    .sys_clk        (sys_clk),
    .sys_reset      (sys_reset),
    .cpu_load       (cpu_load),
    .cpu_store      (cpu_store),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_funct3     (cpu_funct3),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .cpu_misaligned (cpu_misaligned),
    .cpu_bus_error  (cpu_bus_error),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus request monitor: compare captured request fields on each rising bus_req.
  logic req_prev = 1'b0;
  always @(posedge sys_clk) begin
    #1;
    if (bus_req && !req_prev) begin
      if (bus_q.size() == 0) begin
        check("unexpected_bus_req", 32'd1, 32'd0);
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        check("bus_we", {31'b0, bus_we}, {31'b0, e.we});
        check("bus_addr", bus_addr, e.addr);
        check("bus_wdata", bus_wdata, e.wdata);
        check("bus_be", {28'b0, bus_be}, {28'b0, e.be});
      end
    end
    req_prev = bus_req;
  end

  // Core response monitor: DONE is the cycle the core is requesting but not stalled.
  always @(posedge sys_clk) begin
    #1;
    if (!sys_reset && (cpu_load || cpu_store) && !cpu_stall) begin
      if (resp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("cpu_rdata", cpu_rdata, r.rdata);
        check("cpu_bus_error", {31'b0, cpu_bus_error}, {31'b0, r.err});
        check("cpu_misaligned", {31'b0, cpu_misaligned}, {31'b0, r.mis});
      end
    end
  end

  // ack_delay < 0 means never ack.
  task automatic do_access(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int ack_delay, input logic [31:0] rd,
                           input logic has_bus, input bus_t eb, input resp_t er,
                           input int exp_stall, input int exp_req);
    int stall_cnt;
    int req_cnt;
    bit done;
    stall_cnt = 0;
    req_cnt = 0;
    done = 0;
    if (has_bus) bus_q.push_back(eb);
    resp_q.push_back(er);
    @(negedge sys_clk);
    cpu_load = ld;
    cpu_store = st;
    cpu_addr = addr;
    cpu_wdata = wd;
    cpu_funct3 = f3;
    bus_rdata = rd;
    #1;
    if (cpu_stall) stall_cnt++;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      bus_ack = 1'b0;
      if (!cpu_stall) begin
        done = 1;
        break;
      end
      stall_cnt++;
      if (bus_req) begin
        if (req_cnt == ack_delay) bus_ack = 1'b1;
        req_cnt++;
      end
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("stall_cycles", stall_cnt, exp_stall);
      check("req_cycles", req_cnt, exp_req);
      @(negedge sys_clk);
      // Held request must stall again: DONE lasts exactly one cycle.
      check("done_one_cycle", {31'b0, cpu_stall}, 32'd1);
    end
    cpu_load = 1'b0;
    cpu_store = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t  eb;
    resp_t er;
    bus_t  nb;
    nb = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};

    repeat (2) @(negedge sys_clk);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_we", {31'b0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_be", {28'b0, bus_be}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_err", {31'b0, cpu_bus_error}, 32'd0);
    check("rst_mis", {31'b0, cpu_misaligned}, 32'd0);
    sys_reset = 1'b0;

    // Ack while idle is ignored.
    @(negedge sys_clk);
    bus_ack = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("idle_ack_req", {31'b0, bus_req}, 32'd0);
    check("idle_ack_stall", {31'b0, cpu_stall}, 32'd0);
    bus_ack = 1'b0;

    // SW 0x100
    eb = '{we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF, be: 4'b1111};
    er = '{rdata: 32'h0, err: 1'b0, mis: 1'b0};
    do_access(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1, eb, er, 2, 1);
    // LB / LBU 0x103, LH 0x102
    eb = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b1000};
    er = '{rdata: 32'hFFFFFF80, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h103, 32'h0, 3'b000, 0, 32'h80112233, 1, eb, er, 2, 1);
    er = '{rdata: 32'h00000080, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h103, 32'h0, 3'b100, 0, 32'h80112233, 1, eb, er, 2, 1);
    eb = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b1100};
    er = '{rdata: 32'hFFFF8011, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h102, 32'h0, 3'b001, 0, 32'h80112233, 1, eb, er, 2, 1);
    // SB 0x201
    eb = '{we: 1'b1, addr: 32'h200, wdata: 32'hABABABAB, be: 4'b0010};
    er = '{rdata: 32'h0, err: 1'b0, mis: 1'b0};
    do_access(0, 1, 32'h201, 32'h000000AB, 3'b000, 0, 32'h0, 1, eb, er, 2, 1);
    // LHU 0x100 with two wait cycles
    eb = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b0011};
    er = '{rdata: 32'h00002233, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h100, 32'h0, 3'b101, 2, 32'h80112233, 1, eb, er, 4, 3);
    // SH 0x202
    eb = '{we: 1'b1, addr: 32'h200, wdata: 32'hCDEFCDEF, be: 4'b1100};
    er = '{rdata: 32'h0, err: 1'b0, mis: 1'b0};
    do_access(0, 1, 32'h202, 32'h1234CDEF, 3'b001, 0, 32'h0, 1, eb, er, 2, 1);
    // LW timeout (no ack), then ack on the 4th access cycle
    eb = '{we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'b1111};
    er = '{rdata: 32'h0, err: 1'b1, mis: 1'b0};
    do_access(1, 0, 32'h300, 32'h0, 3'b010, -1, 32'h77777777, 1, eb, er, 5, 4);
    er = '{rdata: 32'h12345678, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h300, 32'h0, 3'b010, 3, 32'h12345678, 1, eb, er, 5, 4);
    // LW 0x102
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    er = '{rdata: 32'h0, err: 1'b0, mis: 1'b1};
    do_access(1, 0, 32'h102, 32'h0, 3'b010, 0, 32'hCAFEF00D, 0, nb, er, 1, 0);
`else
    eb = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b1111};
    er = '{rdata: 32'hCAFEF00D, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h102, 32'h0, 3'b010, 0, 32'hCAFEF00D, 1, eb, er, 2, 1);
`endif
    // Load and store both raised: plain load, no write
    eb = '{we: 1'b0, addr: 32'h104, wdata: 32'h0, be: 4'b1111};
    er = '{rdata: 32'h55AA55AA, err: 1'b0, mis: 1'b0};
    do_access(1, 1, 32'h104, 32'hFFFFFFFF, 3'b010, 0, 32'h55AA55AA, 1, eb, er, 2, 1);
    // funct3 size 11 acts as word
    eb = '{we: 1'b1, addr: 32'h10C, wdata: 32'h0BADF00D, be: 4'b1111};
    er = '{rdata: 32'h0, err: 1'b0, mis: 1'b0};
    do_access(0, 1, 32'h10C, 32'h0BADF00D, 3'b011, 1, 32'h0, 1, eb, er, 3, 2);

    // Reset in the middle of an access
    eb = '{we: 1'b0, addr: 32'h400, wdata: 32'h0, be: 4'b1111};
    bus_q.push_back(eb);
    @(negedge sys_clk);
    cpu_load = 1'b1;
    cpu_addr = 32'h400;
    cpu_funct3 = 3'b010;
    @(negedge sys_clk);
    check("req_before_reset", {31'b0, bus_req}, 32'd1);
    #2;
    sys_reset = 1'b1;
    #1;
    check("req_async_drop", {31'b0, bus_req}, 32'd0);
    @(negedge sys_clk);
    cpu_load = 1'b0;
    sys_reset = 1'b0;
    @(negedge sys_clk);
    check("post_reset_req", {31'b0, bus_req}, 32'd0);
    eb = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b1000};
    er = '{rdata: 32'hFFFFFF80, err: 1'b0, mis: 1'b0};
    do_access(1, 0, 32'h103, 32'h0, 3'b000, 0, 32'h80112233, 1, eb, er, 2, 1);

    repeat (3) @(negedge sys_clk);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("resp_q_drained", resp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
